dmem_responder: RTL

Data-memory responder at the far end of the MEM stage's data-memory request interface. It accepts one read or write request at a time from the pipeline's `read_En`/`write_En`/`DataAddress`/`WriteData` signals and inserts a programmable number of wait states. It completes the access against an internal word array and returns read data with a one-cycle ready pulse. `mem_busy` gives the hazard logic a stall signal so the pipeline holds the request until it is serviced.

---
 rtl/dmem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one access at a time, WAIT programmable
// wait states, registered one-cycle ready pulse with error qualification.
module dmem_responder #(
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_En,
   input  logic        write_En,
   input  logic [31:0] DataAddress,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        mem_ready,
   output logic        mem_busy,
   output logic        addr_error
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAITS = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t        state_r;
   logic [3:0]    cnt_r;
   logic          is_read_r;
   logic          err_r;
   logic [AW-1:0] idx_r;
   logic [31:0]   data_r;
   logic [31:0]   mem [DEPTH];

   logic          req_s;
   logic          err_s;
   logic [AW-1:0] idx_s;
   logic          resp_read_s;
   logic          resp_err_s;
   logic [AW-1:0] resp_idx_s;
   logic [31:0]   resp_rdata_s;

   function automatic logic access_error(input logic [31:0] addr, input logic rd, input logic wr);
      return (addr[1:0] != 2'b00) || ({1'b0, addr} >= LIMIT) || (rd && wr);
   endfunction

   // Request decode at the pipeline boundary
   always_comb begin
      req_s = read_En | write_En;
      err_s = access_error(DataAddress, read_En, write_En);
      idx_s = DataAddress[AW+1:2];
   end

   // Values driving the response registers on entry to RESP; with no wait states
   // the access goes straight from IDLE, before the latches hold anything.
   always_comb begin
      resp_read_s  = is_read_r;
      resp_err_s   = err_r;
      resp_idx_s   = idx_r;
      resp_rdata_s = ReadData;
      if (state_r == IDLE) begin
         resp_read_s = read_En;
         resp_err_s  = err_s;
         resp_idx_s  = idx_s;
      end else begin
         resp_read_s = is_read_r;
      end
      if (resp_err_s) begin
         resp_rdata_s = 32'd0;
      end else if (resp_read_s) begin
         resp_rdata_s = mem[resp_idx_s];
      end else begin
         resp_rdata_s = ReadData;
      end
   end

   // Stall to the hazard unit; low in RESP so the pipeline advances with mem_ready
   always_comb begin
      mem_busy = 1'b0;
      if (state_r == WAITS) begin
         mem_busy = 1'b1;
      end else if (state_r == IDLE) begin
         mem_busy = req_s;
      end else begin
         mem_busy = 1'b0;
      end
   end

   // Access sequencer with registered response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         is_read_r  <= 1'b0;
         err_r      <= 1'b0;
         idx_r      <= '0;
         data_r     <= 32'd0;
         ReadData   <= 32'd0;
         mem_ready  <= 1'b0;
         addr_error <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               mem_ready  <= 1'b0;
               addr_error <= 1'b0;
               if (req_s) begin
                  is_read_r <= read_En;
                  err_r     <= err_s;
                  idx_r     <= idx_s;
                  data_r    <= WriteData;
                  cnt_r     <= WAIT_CNT;
                  if (WAIT_CNT != 4'd0) begin
                     state_r <= WAITS;
                  end else begin
                     state_r    <= RESP;
                     mem_ready  <= 1'b1;
                     addr_error <= resp_err_s;
                     ReadData   <= resp_rdata_s;
                  end
               end
            end
            WAITS: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  state_r    <= RESP;
                  mem_ready  <= 1'b1;
                  addr_error <= resp_err_s;
                  ReadData   <= resp_rdata_s;
               end
            end
            RESP: begin
               state_r    <= IDLE;
               mem_ready  <= 1'b0;
               addr_error <= 1'b0;
            end
            default: begin
               state_r    <= IDLE;
               mem_ready  <= 1'b0;
               addr_error <= 1'b0;
            end
         endcase
      end
   end

   // Word array: commits at the end of RESP; reset on that edge cancels the write
   always_ff @(posedge clk) begin
      if (!reset && (state_r == RESP) && !is_read_r && !err_r) begin
         mem[idx_r] <= data_r;
      end
   end

endmodule
